// File: rtl/voice_allocator_if.sv
// rtl/voice_allocator_if.sv - note event handshake bundle between midi_decoder and voice_allocator
interface voice_allocator_if;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_on;
  logic [7:0] ev_key;
  logic [7:0] ev_vel;

  modport master (
    output ev_valid,
    output ev_on,
    output ev_key,
    output ev_vel,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_on,
    input  ev_key,
    input  ev_vel,
    output ev_ready
  );
endinterface

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - assigns MIDI note events to synth voices; VOICE_STEAL_EN enables oldest-voice stealing
module voice_allocator #(
  parameter int VOICES    = 8,
  parameter int V_WIDTH   = 3,
  parameter int NOTE_HOLD = 64,
  parameter int AGE_W     = 8
) (
  input  logic               OSC_CLK,
  input  logic               reset_reg_N,
  voice_allocator_if.slave   ev,
  input  logic [VOICES-1:0]  voice_free,
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off,
  output logic               ev_dropped,
  output logic               ev_stolen
);

  localparam int HW = $clog2(NOTE_HOLD + 1);
  localparam logic [HW-1:0]      HOLD_LAST = HW'(NOTE_HOLD - 1);
  localparam logic [HW-1:0]      HOLD_END  = HW'(NOTE_HOLD);
  localparam logic [V_WIDTH-1:0] LAST_IDX  = V_WIDTH'(VOICES - 1);

  typedef enum logic [2:0] {IDLE, SCAN, DECIDE, ISSUE, HOLD} state_t;
  state_t state, state_nxt;

  logic               accept;
  logic               ev_on_q;
  logic [7:0]         ev_key_q;
  logic [7:0]         ev_vel_q;
  logic [VOICES-1:0]  snap_free;
  logic [7:0]         key_tbl [VOICES];
  logic [V_WIDTH-1:0] scan_idx;
  logic               match_found;
  logic [V_WIDTH-1:0] match_idx;
  logic               free_found;
  logic [V_WIDTH-1:0] free_idx;
  logic [HW-1:0]      hold_cnt;
  logic               tgt_ok;
  logic [V_WIDTH-1:0] tgt_idx;
  logic               do_issue;

`ifdef VOICE_STEAL_EN
  logic [AGE_W-1:0]   age [VOICES];
  logic [V_WIDTH-1:0] oldest_idx;
  logic [AGE_W-1:0]   oldest_age;
  logic               tgt_steal;
`endif

  assign accept   = ev.ev_valid & ev.ev_ready;
  assign do_issue = (state == DECIDE) & tgt_ok;

  // FSM state register
  always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) state <= IDLE;
    else              state <= state_nxt;
  end

  // FSM next state, handshake ready and drop strobe
  always_comb begin
    state_nxt   = state;
    ev.ev_ready = 1'b0;
    ev_dropped  = 1'b0;
    case (state)
      IDLE: begin
        ev.ev_ready = 1'b1;
        if (accept) state_nxt = SCAN;
      end
      SCAN:   if (scan_idx == LAST_IDX) state_nxt = DECIDE;
      DECIDE: begin
        ev_dropped = ~tgt_ok;
        state_nxt  = tgt_ok ? ISSUE : IDLE;
      end
      ISSUE:  state_nxt = ev_on_q ? HOLD : IDLE;
      HOLD:   if (hold_cnt == HOLD_END) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Target choice: retrigger match, else lowest free, else (optionally) oldest
  always_comb begin
    tgt_ok  = 1'b0;
    tgt_idx = '0;
`ifdef VOICE_STEAL_EN
    tgt_steal = 1'b0;
`endif
    if (ev_on_q) begin
      if (match_found) begin
        tgt_ok  = 1'b1;
        tgt_idx = match_idx;
      end else if (free_found) begin
        tgt_ok  = 1'b1;
        tgt_idx = free_idx;
      end else begin
`ifdef VOICE_STEAL_EN
        tgt_ok    = 1'b1;
        tgt_idx   = oldest_idx;
        tgt_steal = 1'b1;
`else
        tgt_ok    = 1'b0;
`endif
      end
    end else if (match_found) begin
      tgt_ok  = 1'b1;
      tgt_idx = match_idx;
    end
  end

  // Event snapshot on accept; voice_free is frozen for the whole event
  always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      ev_on_q   <= 1'b0;
      ev_key_q  <= '0;
      ev_vel_q  <= '0;
      snap_free <= '0;
    end else if (accept) begin
      ev_on_q   <= ev.ev_on;
      ev_key_q  <= ev.ev_key;
      ev_vel_q  <= ev.ev_vel;
      snap_free <= voice_free;
    end
  end

  // Voice sweep, one voice per cycle, recording first match, first free and oldest
  always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      scan_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
`ifdef VOICE_STEAL_EN
      oldest_idx  <= '0;
      oldest_age  <= '0;
`endif
    end else if (accept) begin
      scan_idx    <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
    end else if (state == SCAN) begin
      if (!match_found && keys_on[scan_idx] && (key_tbl[scan_idx] == ev_key_q)) begin
        match_found <= 1'b1;
        match_idx   <= scan_idx;
      end
      if (!free_found && snap_free[scan_idx] && !keys_on[scan_idx]) begin
        free_found <= 1'b1;
        free_idx   <= scan_idx;
      end
`ifdef VOICE_STEAL_EN
      if ((scan_idx == '0) || (age[scan_idx] > oldest_age)) begin
        oldest_idx <= scan_idx;
        oldest_age <= age[scan_idx];
      end
`endif
      scan_idx <= scan_idx + 1'b1;
    end
  end

  // Engine-facing outputs, key table and note_on hold timer
  always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      keys_on     <= '0;
      note_on     <= 1'b0;
      cur_key_adr <= '0;
      cur_key_val <= '0;
      cur_vel_on  <= '0;
      cur_vel_off <= '0;
      hold_cnt    <= '0;
      for (int i = 0; i < VOICES; i++) key_tbl[i] <= '0;
    end else if (do_issue) begin
      cur_key_adr <= tgt_idx;
      cur_key_val <= ev_key_q;
      hold_cnt    <= '0;
      if (ev_on_q) begin
        keys_on[tgt_idx] <= 1'b1;
        key_tbl[tgt_idx] <= ev_key_q;
        cur_vel_on       <= ev_vel_q;
        note_on          <= 1'b1;
      end else begin
        keys_on[tgt_idx] <= 1'b0;
        cur_vel_off      <= ev_vel_q;
      end
    end else if ((state == ISSUE) || (state == HOLD)) begin
      hold_cnt <= hold_cnt + 1'b1;
      if (hold_cnt == HOLD_LAST) note_on <= 1'b0;
    end
  end

`ifdef VOICE_STEAL_EN
  // Steal strobe, visible during the issue cycle
  always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) ev_stolen <= 1'b0;
    else              ev_stolen <= do_issue & ev_on_q & tgt_steal;
  end

  // Voice ages: issued voice restarts at 0, every other voice ages by one (saturating)
  always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      for (int i = 0; i < VOICES; i++) age[i] <= '0;
    end else if (do_issue && ev_on_q) begin
      for (int i = 0; i < VOICES; i++) begin
        if (V_WIDTH'(i) == tgt_idx)  age[i] <= '0;
        else if (age[i] != '1)       age[i] <= age[i] + 1'b1;
      end
    end
  end
`else
  assign ev_stolen = 1'b0;
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed scoreboard bench for voice_allocator
module tb_voice_allocator;

  typedef struct {
    logic       drop;
    logic [7:0] keys;
    logic [2:0] adr;
    logic [7:0] key;
    logic [7:0] von;
    logic [7:0] voff;
    logic       on;
    logic       stolen;
  } exp_t;

  logic       OSC_CLK;
  logic       reset_reg_N;
  logic [7:0] voice_free;
  logic [7:0] keys_on;
  logic       note_on;
  logic [2:0] cur_key_adr;
  logic [7:0] cur_key_val;
  logic [7:0] cur_vel_on;
  logic [7:0] cur_vel_off;
  logic       ev_dropped;
  logic       ev_stolen;

  int   total  = 0;
  int   passed = 0;
  exp_t exp_q[$];

  voice_allocator_if bus();

  voice_allocator #(.VOICES(8), .V_WIDTH(3), .NOTE_HOLD(64), .AGE_W(8)) dut (
    .OSC_CLK     (OSC_CLK),
    .reset_reg_N (reset_reg_N),
    .ev          (bus),
    .voice_free  (voice_free),
    .keys_on     (keys_on),
    .note_on     (note_on),
    .cur_key_adr (cur_key_adr),
    .cur_key_val (cur_key_val),
    .cur_vel_on  (cur_vel_on),
    .cur_vel_off (cur_vel_off),
    .ev_dropped  (ev_dropped),
    .ev_stolen   (ev_stolen)
  );

  initial OSC_CLK = 1'b0;
  always #5 OSC_CLK = ~OSC_CLK;

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic exp_t iss(input logic [7:0] keys, input logic [2:0] adr, input logic [7:0] key,
                               input logic [7:0] von, input logic [7:0] voff, input logic on,
                               input logic stolen);
    exp_t e;
    e.drop = 1'b0; e.keys = keys; e.adr = adr; e.key = key;
    e.von = von; e.voff = voff; e.on = on; e.stolen = stolen;
    return e;
  endfunction

  function automatic exp_t drp(input logic [7:0] keys, input logic [7:0] key);
    exp_t e;
    e.drop = 1'b1; e.keys = keys; e.adr = '0; e.key = key;
    e.von = '0; e.voff = '0; e.on = 1'b0; e.stolen = 1'b0;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge OSC_CLK);
    reset_reg_N = 1'b0;
    #1;
    chk("rst_keys_on", keys_on, 0);
    chk("rst_note_on", note_on, 0);
    chk("rst_ready", bus.ev_ready, 1);
    repeat (2) @(negedge OSC_CLK);
    reset_reg_N = 1'b1;
    chk("rst_cur", {cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off}, 0);
    chk("rst_strobes", {ev_dropped, ev_stolen}, 0);
  endtask

  // Cycle n counts negedges after the accepting posedge (accept cycle = 0)
  task automatic run_event(input logic on, input logic [7:0] key, input logic [7:0] vel,
                           input exp_t e, input bit wait_done);
    int   n;
    exp_t x;
    exp_q.push_back(e);
    n = 0;
    while (bus.ev_ready !== 1'b1 && n < 200) begin
      @(negedge OSC_CLK);
      n++;
    end
    chk("ready_wait", bus.ev_ready, 1);
    bus.ev_valid = 1'b1;
    bus.ev_on    = on;
    bus.ev_key   = key;
    bus.ev_vel   = vel;
    @(posedge OSC_CLK);
    @(negedge OSC_CLK);
    bus.ev_valid = 1'b0;
    chk("ready_low", bus.ev_ready, 0);
    repeat (8) @(negedge OSC_CLK);
    x = exp_q.pop_front();
    chk("dropped_c9", ev_dropped, x.drop);
    @(negedge OSC_CLK);
    if (x.drop) begin
      chk("ready_c10_drop", bus.ev_ready, 1);
      chk("keys_unchanged", keys_on, x.keys);
      chk("key_unchanged", cur_key_val, x.key);
      chk("drop_note_on", note_on, 0);
    end else begin
      chk("keys_on", keys_on, x.keys);
      chk("cur_key_adr", cur_key_adr, x.adr);
      chk("cur_key_val", cur_key_val, x.key);
      chk("cur_vel_on", cur_vel_on, x.von);
      chk("cur_vel_off", cur_vel_off, x.voff);
      chk("note_on_c10", note_on, x.on);
      chk("ev_stolen", ev_stolen, x.stolen);
      if (wait_done) begin
        n = 10;
        while (note_on === 1'b1 && n < 300) begin
          @(negedge OSC_CLK);
          n++;
        end
        if (x.on) chk("note_on_fall_cycle", n, 74);
        while (bus.ev_ready !== 1'b1 && n < 300) begin
          @(negedge OSC_CLK);
          n++;
        end
        chk("ready_return_cycle", n, x.on ? 75 : 11);
      end
    end
  endtask

  initial begin
    reset_reg_N  = 1'b1;
    voice_free   = 8'hFF;
    bus.ev_valid = 1'b0;
    bus.ev_on    = 1'b0;
    bus.ev_key   = '0;
    bus.ev_vel   = '0;

    // single note-on, allocation, key release, unheld release
    do_reset();
    run_event(1, 60, 100, iss(8'h01, 0, 60, 100, 0, 1, 0), 1);
    run_event(1, 62, 90,  iss(8'h03, 1, 62, 90,  0, 1, 0), 1);
    run_event(1, 64, 80,  iss(8'h07, 2, 64, 80,  0, 1, 0), 1);
    run_event(0, 62, 40,  iss(8'h05, 1, 62, 80, 40, 0, 0), 1);
    chk("off_note_on_low", note_on, 0);
    run_event(0, 99, 30,  drp(8'h05, 62), 0);

    // retrigger of a held key and lowest free voice with busy envelopes
    do_reset();
    run_event(1, 60, 100, iss(8'h01, 0, 60, 100, 0, 1, 0), 1);
    run_event(1, 60, 120, iss(8'h01, 0, 60, 120, 0, 1, 0), 1);
    voice_free = 8'hFC;
    run_event(1, 50, 70,  iss(8'h05, 2, 50, 70, 0, 1, 0), 1);
    voice_free = 8'hFF;

    // all voices busy
    do_reset();
    for (int i = 0; i < 8; i++) begin
      logic [8:0] m;
      m = (9'd1 << (i + 1)) - 9'd1;
      run_event(1, 8'(60 + i), 100, iss(m[7:0], 3'(i), 8'(60 + i), 100, 0, 1, 0), 1);
    end
    voice_free = 8'h00;
`ifdef VOICE_STEAL_EN
    run_event(1, 70, 50, iss(8'hFF, 0, 70, 50, 0, 1, 1), 1);
    run_event(0, 60, 10, drp(8'hFF, 70), 0);
    run_event(1, 71, 55, iss(8'hFF, 1, 71, 55, 0, 1, 1), 1);
    run_event(0, 70, 20, iss(8'hFE, 0, 70, 55, 20, 0, 0), 1);
`else
    run_event(1, 70, 50, drp(8'hFF, 67), 0);
    chk("no_steal_pulse", ev_stolen, 0);
    run_event(0, 60, 10, iss(8'hFE, 0, 60, 100, 10, 0, 0), 1);
    run_event(1, 70, 50, drp(8'hFE, 60), 0);
    voice_free = 8'h01;
    run_event(1, 70, 50, iss(8'hFF, 0, 70, 50, 10, 1, 0), 1);
`endif
    voice_free = 8'hFF;

    // reset during HOLD
    do_reset();
    run_event(1, 60, 1, iss(8'h01, 0, 60, 1, 0, 1, 0), 1);
    run_event(1, 61, 2, iss(8'h03, 1, 61, 2, 0, 1, 0), 1);
    run_event(1, 62, 3, iss(8'h07, 2, 62, 3, 0, 1, 0), 1);
    run_event(1, 63, 4, iss(8'h0F, 3, 63, 4, 0, 1, 0), 0);
    repeat (5) @(negedge OSC_CLK);
    chk("hold_note_on", note_on, 1);
    chk("hold_busy", bus.ev_ready, 0);
    reset_reg_N = 1'b0;
    #1;
    chk("async_rst_keys", keys_on, 0);
    chk("async_rst_note_on", note_on, 0);
    repeat (2) @(negedge OSC_CLK);
    reset_reg_N = 1'b1;
    @(negedge OSC_CLK);
    chk("ready_after_release", bus.ev_ready, 1);
    run_event(1, 64, 33, iss(8'h01, 0, 64, 33, 0, 1, 0), 1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
